// File: rtl/amt_pkg.sv
// amt_pkg: shared state encoding, default geometry, tag/address types and the repair beat-count helper
package amt_pkg;
   localparam int AMT_DEPTH = 32;
   localparam int AMT_WIDTH = 7;
   localparam int AMT_INDEX = $clog2(AMT_DEPTH);
   typedef enum logic {IDLE, REPAIR} amt_state_t;
   typedef logic [AMT_INDEX-1:0] amt_addr_t;
   typedef logic [AMT_WIDTH-1:0] amt_tag_t;
   function automatic int amt_beats(input int depth, input int n_packets);
      return (depth + n_packets - 1) / n_packets;
   endfunction
endpackage

// File: rtl/amt_repair_seq.sv
// amt_repair_seq: repair streamer walking the table N_PACKETS entries per beat
//   clk, reset       clock, async active-high reset
//   repairStart_i    request a full table stream (ignored while streaming)
//   table_i          current table contents
//   repair*_o        registered beat: valid, per-packet index/tag/mask, done on last beat
//   amtReady_o       high while idle
module amt_repair_seq
   import amt_pkg::*;
#(
   parameter int DEPTH     = 32,
   parameter int INDEX     = $clog2(DEPTH),
   parameter int WIDTH     = 7,
   parameter int N_PACKETS = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                repairStart_i,
   input  logic [DEPTH-1:0][WIDTH-1:0]         table_i,
   output logic                                repairValid_o,
   output logic [N_PACKETS-1:0][INDEX-1:0]     repairAddr_o,
   output logic [N_PACKETS-1:0][WIDTH-1:0]     repairData_o,
   output logic [N_PACKETS-1:0]                repairMask_o,
   output logic                                repairDone_o,
   output logic                                amtReady_o
);
   localparam int BEATS = amt_beats(DEPTH, N_PACKETS);
   localparam int CW    = $clog2(BEATS + 1);
   localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
   amt_state_t                                  state;
   logic [CW-1:0]                               cnt;
   logic                                        last;
   logic [BEATS-1:0][N_PACKETS-1:0][WIDTH-1:0]  pad;
   logic [BEATS-1:0][N_PACKETS-1:0]             valid_map;
   // zero-extending the table to a whole number of beats makes packets past DEPTH read as 0
   assign pad        = (BEATS*N_PACKETS*WIDTH)'(table_i);
   assign valid_map  = (BEATS*N_PACKETS)'({DEPTH{1'b1}});
   assign last       = cnt == CW'(BEATS - 1);
   assign amtReady_o = state == IDLE;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         repairValid_o <= 1'b0;
         repairDone_o  <= 1'b0;
         repairAddr_o  <= '0;
         repairData_o  <= '0;
         repairMask_o  <= '0;
      end else if (state == IDLE) begin
         state         <= repairStart_i ? REPAIR : IDLE;
         cnt           <= '0;
         repairValid_o <= 1'b0;
         repairDone_o  <= 1'b0;
         repairAddr_o  <= '0;
         repairData_o  <= '0;
         repairMask_o  <= '0;
      end else begin
         state         <= last ? IDLE : REPAIR;
         cnt           <= last ? '0 : cnt + 1'b1;
         repairValid_o <= 1'b1;
         repairDone_o  <= last;
         for (int k = 0; k < N_PACKETS; k++)
            repairAddr_o[k] <= INDEX'(int'(cnt) * N_PACKETS + k);
         repairData_o  <= pad[cnt[BW-1:0]];
         repairMask_o  <= valid_map[cnt[BW-1:0]];
      end
endmodule

// File: rtl/amt_stream_table.sv
// amt_stream_table: architectural map table with prioritised commit writes, combinational reads and a repair streamer
//   clk, reset              clock, async active-high reset (table returns to identity)
//   laneActive_i, we_i      per-lane write enable and activity mask
//   wrAddr_i, wrData_i      commit writes; highest active lane wins on address collisions
//   rdAddr_i, rdData_o      combinational commit reads of the stored array (no bypass)
//   repairStart_i           start a full-table stream to the RMT
//   repair*_o, amtReady_o   streamed beats; writes are dropped while amtReady_o is low
module amt_stream_table
   import amt_pkg::*;
#(
   parameter int NUM_RPORT = 4,
   parameter int NUM_WPORT = 4,
   parameter int DEPTH     = 32,
   parameter int INDEX     = $clog2(DEPTH),
   parameter int WIDTH     = 7,
   parameter int N_PACKETS = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_WPORT-1:0]                laneActive_i,
   input  logic [NUM_RPORT-1:0][INDEX-1:0]     rdAddr_i,
   output logic [NUM_RPORT-1:0][WIDTH-1:0]     rdData_o,
   input  logic [NUM_WPORT-1:0][INDEX-1:0]     wrAddr_i,
   input  logic [NUM_WPORT-1:0][WIDTH-1:0]     wrData_i,
   input  logic [NUM_WPORT-1:0]                we_i,
   input  logic                                repairStart_i,
   output logic                                repairValid_o,
   output logic [N_PACKETS-1:0][INDEX-1:0]     repairAddr_o,
   output logic [N_PACKETS-1:0][WIDTH-1:0]     repairData_o,
   output logic [N_PACKETS-1:0]                repairMask_o,
   output logic                                repairDone_o,
   output logic                                amtReady_o
);
   logic [DEPTH-1:0][WIDTH-1:0] ram;
   // later loop iterations override earlier ones, so the highest lane wins a collision
   always_ff @(posedge clk or posedge reset)
      if (reset)
         for (int i = 0; i < DEPTH; i++) ram[i] <= WIDTH'(i);
      else
         for (int k = 0; k < NUM_WPORT; k++)
            if (we_i[k] && laneActive_i[k] && amtReady_o) ram[wrAddr_i[k]] <= wrData_i[k];
   always_comb
      for (int k = 0; k < NUM_RPORT; k++) rdData_o[k] = ram[rdAddr_i[k]];
   amt_repair_seq #(
      .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .N_PACKETS(N_PACKETS)
   ) u_seq (
      .clk(clk),
      .reset(reset),
      .repairStart_i(repairStart_i),
      .table_i(ram),
      .repairValid_o(repairValid_o),
      .repairAddr_o(repairAddr_o),
      .repairData_o(repairData_o),
      .repairMask_o(repairMask_o),
      .repairDone_o(repairDone_o),
      .amtReady_o(amtReady_o)
   );
endmodule
